// File: rtl/ascensor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ascensor_pkg
//  Purpose  : Shared state encoding and default sizing for the elevator
//             controller and its request latch.
//  Revision : 1.0 - initial release
// ============================================================================
package ascensor_pkg;

    // Default sizing
    localparam int N_FLOORS_DEF     = 8;
    localparam int DOOR_TICKS_DEF   = 10;
    localparam int TRAVEL_TICKS_DEF = 4;

    // Width of the floor index port
    localparam int FLOOR_W = 3;

    // Controller state encoding
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_DOOR_OPEN = 2'd1;
    localparam logic [1:0] ST_MOVE_UP   = 2'd2;
    localparam logic [1:0] ST_MOVE_DN   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/req_latch.sv
`default_nettype none
// ============================================================================
//  Module   : req_latch
//  Purpose  : Holds outstanding floor calls. A call is latched on any edge
//             its button is high and is cleared while the door is open at
//             that floor (clear beats set). Also reports whether a call
//             exists at, above or below a look-up floor.
//  Revision : 1.0 - initial release
// ============================================================================
module req_latch
    import ascensor_pkg::*;
#(
    parameter int N_FLOORS = N_FLOORS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_FLOORS-1:0] req,
    input  logic                clr_en,
    input  logic [FLOOR_W-1:0]  clr_floor,
    input  logic [FLOOR_W-1:0]  look_floor,
    output logic [N_FLOORS-1:0] pending,
    output logic                hit,
    output logic                any_above,
    output logic                any_below
);

    logic [N_FLOORS-1:0] clr;

    // One clear strobe per floor, active only for the floor being served
    generate
        for (genvar i = 0; i < N_FLOORS; i++) begin : g_clr
            assign clr[i] = clr_en && (int'(clr_floor) == i);
        end
    endgenerate

    // Pending register bank: set by button, clear has priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending | req) & ~clr;
        end
    end

    // Classify outstanding calls relative to the look-up floor
    always_comb begin
        hit       = 1'b0;
        any_above = 1'b0;
        any_below = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (pending[i]) begin
                if (i == int'(look_floor)) hit = 1'b1;
                if (i >  int'(look_floor)) any_above = 1'b1;
                if (i <  int'(look_floor)) any_below = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ascensor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ascensor_ctrl
//  Purpose  : Single-car elevator controller. Drives an external 4-bit
//             load/count timer for door dwell and per-floor travel time,
//             serves latched calls with a keep-direction policy.
//  Revision : 1.0 - initial release
// ============================================================================
module ascensor_ctrl
    import ascensor_pkg::*;
#(
    parameter int N_FLOORS     = N_FLOORS_DEF,
    parameter int DOOR_TICKS   = DOOR_TICKS_DEF,
    parameter int TRAVEL_TICKS = TRAVEL_TICKS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_FLOORS-1:0] req,
    output logic                tmr_enb,
    output logic                tmr_modo,
    output logic [3:0]          tmr_data,
    input  logic [3:0]          tmr_q,
    output logic [FLOOR_W-1:0]  floor,
    output logic                dir_up,
    output logic                moving,
    output logic                door_open,
    output logic [N_FLOORS-1:0] pending
);

    localparam logic [FLOOR_W-1:0] TOP_FLOOR    = FLOOR_W'(N_FLOORS - 1);
    localparam logic [3:0]         DOOR_LIMIT   = 4'(DOOR_TICKS - 1);
    localparam logic [3:0]         TRAVEL_LIMIT = 4'(TRAVEL_TICKS - 1);

    logic [1:0]         state;
    logic [1:0]         state_nx;
    logic               arm;
    logic               enter;
    logic               dir_nx;
    logic [FLOOR_W-1:0] floor_nx;
    logic [3:0]         limit;
    logic               done;
    logic               hit;
    logic               any_above;
    logic               any_below;

    // The timer is stale on the first cycle of a state (arm), so it is only
    // trusted once the load issued by arm has landed.
    assign limit = (state == ST_DOOR_OPEN) ? DOOR_LIMIT : TRAVEL_LIMIT;
    assign done  = !arm && (tmr_q == limit);

    // Arrival floor: decisions at the end of a hop look at the new floor
    always_comb begin
        floor_nx = floor;
        if (done) begin
            if (state == ST_MOVE_UP && floor != TOP_FLOOR) begin
                floor_nx = floor + 1'b1;
            end else if (state == ST_MOVE_DN && floor != '0) begin
                floor_nx = floor - 1'b1;
            end
        end
    end

    req_latch #(
        .N_FLOORS (N_FLOORS)
    ) u_req_latch (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .clr_en     (state == ST_DOOR_OPEN),
        .clr_floor  (floor),
        .look_floor (floor_nx),
        .pending    (pending),
        .hit        (hit),
        .any_above  (any_above),
        .any_below  (any_below)
    );

    // State register, arm flag, floor and direction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            arm    <= 1'b0;
            floor  <= '0;
            dir_up <= 1'b1;
        end else begin
            state  <= state_nx;
            arm    <= enter;
            floor  <= floor_nx;
            dir_up <= dir_nx;
        end
    end

    // Next-state decision; enter marks every state entry, including a
    // re-entry of MOVE at an intermediate floor, so the timer reloads.
    always_comb begin
        state_nx = state;
        dir_nx   = dir_up;
        enter    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hit) begin
                    state_nx = ST_DOOR_OPEN;
                    enter    = 1'b1;
                end else if (dir_up ? any_above : any_below) begin
                    state_nx = dir_up ? ST_MOVE_UP : ST_MOVE_DN;
                    enter    = 1'b1;
                end else if (dir_up ? any_below : any_above) begin
                    dir_nx   = !dir_up;
                    state_nx = dir_up ? ST_MOVE_DN : ST_MOVE_UP;
                    enter    = 1'b1;
                end
            end
            ST_DOOR_OPEN: begin
                if (done) begin
                    state_nx = ST_IDLE;
                    enter    = 1'b1;
                end
            end
            ST_MOVE_UP: begin
                if (done) begin
                    enter = 1'b1;
                    if (hit)            state_nx = ST_DOOR_OPEN;
                    else if (any_above) state_nx = ST_MOVE_UP;
                    else                state_nx = ST_IDLE;
                end
            end
            ST_MOVE_DN: begin
                if (done) begin
                    enter = 1'b1;
                    if (hit)            state_nx = ST_DOOR_OPEN;
                    else if (any_below) state_nx = ST_MOVE_DN;
                    else                state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Status flags and timer port decode
    always_comb begin
        moving    = (state == ST_MOVE_UP) || (state == ST_MOVE_DN);
        door_open = (state == ST_DOOR_OPEN);
        tmr_enb   = 1'b0;
        tmr_modo  = 1'b0;
        tmr_data  = 4'd0;
        if (arm) begin
            tmr_enb  = 1'b1;
            tmr_modo = 1'b1;
        end else if (state != ST_IDLE) begin
            tmr_enb  = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ascensor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ascensor_ctrl
//  Purpose  : Directed self-checking bench for ascensor_ctrl with a
//             behavioural 4-bit load/count timer attached.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ascensor_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       tmr_enb;
    logic       tmr_modo;
    logic [3:0] tmr_data;
    logic [3:0] tmr_q = 4'd0;
    logic [2:0] floor;
    logic       dir_up;
    logic       moving;
    logic       door_open;
    logic [7:0] pending;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // External counter: load or count, visible one edge later, wraps
    always @(posedge clk) begin
        if (tmr_enb) tmr_q <= tmr_modo ? tmr_data : tmr_q + 4'd1;
    end

    ascensor_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .tmr_enb   (tmr_enb),
        .tmr_modo  (tmr_modo),
        .tmr_data  (tmr_data),
        .tmr_q     (tmr_q),
        .floor     (floor),
        .dir_up    (dir_up),
        .moving    (moving),
        .door_open (door_open),
        .pending   (pending)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until door_open equals lvl (bounded)
    task automatic wait_door(input logic lvl, output int n);
        n = 0;
        while (door_open !== lvl && n < 400) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        req   = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        total++; if (floor !== 3'd0) begin bad++; $display("FAIL reset_floor: got=%0d want=0", floor); end
        total++; if (dir_up !== 1'b1) begin bad++; $display("FAIL reset_dir: got=%b want=1", dir_up); end
        total++; if (moving !== 1'b0 || door_open !== 1'b0) begin bad++; $display("FAIL reset_status: moving=%b door=%b want 0 0", moving, door_open); end
        total++; if (pending !== 8'h00) begin bad++; $display("FAIL reset_pending: got=%h want=00", pending); end
        n = {tmr_enb, tmr_modo, tmr_data};
        total++; if (n !== 0) begin bad++; $display("FAIL reset_tmr: enb=%b modo=%b data=%h want 0 0 0", tmr_enb, tmr_modo, tmr_data); end
    endtask

    task automatic test_door_here();
        int n;
        req = 8'h01;
        tick();
        req = '0;
        total++; if (pending !== 8'h01 || door_open !== 1'b0) begin bad++; $display("FAIL here_latch: pending=%h door=%b want 01 0", pending, door_open); end
        tick();
        total++; if (door_open !== 1'b1 || tmr_enb !== 1'b1 || tmr_modo !== 1'b1) begin bad++; $display("FAIL here_open: door=%b enb=%b modo=%b want 1 1 1", door_open, tmr_enb, tmr_modo); end
        wait_door(1'b0, n);
        total++; if (n !== 11) begin bad++; $display("FAIL here_dwell: got=%0d want=11", n); end
        total++; if (pending !== 8'h00 || moving !== 1'b0 || floor !== 3'd0) begin bad++; $display("FAIL here_after: pending=%h moving=%b floor=%0d want 00 0 0", pending, moving, floor); end
        tick();
        total++; if (tmr_enb !== 1'b0) begin bad++; $display("FAIL here_idle_tmr: got=%b want=0", tmr_enb); end
    endtask

    task automatic test_travel_up();
        int n;
        req = 8'h08;
        tick();
        req = '0;
        total++; if (pending !== 8'h08) begin bad++; $display("FAIL up_latch: got=%h want=08", pending); end
        tick();
        total++; if (moving !== 1'b1 || dir_up !== 1'b1 || floor !== 3'd0) begin bad++; $display("FAIL up_start: moving=%b dir=%b floor=%0d want 1 1 0", moving, dir_up, floor); end
        for (int f = 0; f < 3; f++) begin
            n = 0;
            while (floor === 3'(f) && n < 50) begin
                tick();
                n++;
            end
            total++; if (n !== 5 || floor !== 3'(f + 1)) begin bad++; $display("FAIL up_hop%0d: cycles=%0d floor=%0d want 5 %0d", f, n, floor, f + 1); end
        end
        total++; if (door_open !== 1'b1 || moving !== 1'b0) begin bad++; $display("FAIL up_arrive: door=%b moving=%b want 1 0", door_open, moving); end
        wait_door(1'b0, n);
        total++; if (n !== 11 || pending !== 8'h00) begin bad++; $display("FAIL up_dwell: cycles=%0d pending=%h want 11 00", n, pending); end
    endtask

    task automatic test_both_directions();
        int n;
        req = 8'h42;
        tick();
        req = '0;
        total++; if (pending !== 8'h42) begin bad++; $display("FAIL both_latch: got=%h want=42", pending); end
        tick();
        total++; if (moving !== 1'b1 || dir_up !== 1'b1) begin bad++; $display("FAIL both_start: moving=%b dir=%b want 1 1", moving, dir_up); end
        wait_door(1'b1, n);
        total++; if (n !== 15 || floor !== 3'd6) begin bad++; $display("FAIL both_first: cycles=%0d floor=%0d want 15 6", n, floor); end
        wait_door(1'b0, n);
        total++; if (n !== 11 || moving !== 1'b0 || pending !== 8'h02) begin bad++; $display("FAIL both_close: cycles=%0d moving=%b pending=%h want 11 0 02", n, moving, pending); end
        tick();
        total++; if (moving !== 1'b1 || dir_up !== 1'b0) begin bad++; $display("FAIL both_reverse: moving=%b dir=%b want 1 0", moving, dir_up); end
        wait_door(1'b1, n);
        total++; if (n !== 25 || floor !== 3'd1) begin bad++; $display("FAIL both_second: cycles=%0d floor=%0d want 25 1", n, floor); end
        wait_door(1'b0, n);
        total++; if (pending !== 8'h00) begin bad++; $display("FAIL both_done: pending=%h want 00", pending); end
    endtask

    task automatic test_mid_hop_stop();
        int n;
        // Reposition to floor 3 going up
        req = 8'h08;
        tick();
        req = '0;
        tick();
        total++; if (moving !== 1'b1 || dir_up !== 1'b1) begin bad++; $display("FAIL mid_turn: moving=%b dir=%b want 1 1", moving, dir_up); end
        wait_door(1'b1, n);
        total++; if (n !== 10 || floor !== 3'd3) begin bad++; $display("FAIL mid_reach3: cycles=%0d floor=%0d want 10 3", n, floor); end
        wait_door(1'b0, n);
        // Call 6, then call 5 while still between 3 and 4
        req = 8'h40;
        tick();
        req = '0;
        tick();
        tick();
        tick();
        req = 8'h20;
        tick();
        req = '0;
        total++; if (floor !== 3'd3 || moving !== 1'b1) begin bad++; $display("FAIL mid_inhop: floor=%0d moving=%b want 3 1", floor, moving); end
        wait_door(1'b1, n);
        total++; if (n + 3 !== 10 || floor !== 3'd5) begin bad++; $display("FAIL mid_stop5: cycles=%0d floor=%0d want 10 5", n + 3, floor); end
        wait_door(1'b0, n);
        total++; if (pending !== 8'h40) begin bad++; $display("FAIL mid_keep6: pending=%h want 40", pending); end
        tick();
        wait_door(1'b1, n);
        total++; if (n !== 5 || floor !== 3'd6) begin bad++; $display("FAIL mid_reach6: cycles=%0d floor=%0d want 5 6", n, floor); end
        wait_door(1'b0, n);
    endtask

    task automatic test_reset_mid_hop();
        int n;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        req = 8'h20;
        tick();
        req = '0;
        tick();
        n = 0;
        while (floor !== 3'd2 && n < 50) begin
            tick();
            n++;
        end
        tick();
        tick();
        total++; if (floor !== 3'd2 || moving !== 1'b1 || pending !== 8'h20) begin bad++; $display("FAIL rstmid_pre: floor=%0d moving=%b pending=%h want 2 1 20", floor, moving, pending); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (floor !== 3'd0 || pending !== 8'h00 || moving !== 1'b0 || tmr_enb !== 1'b0) begin bad++; $display("FAIL rstmid_async: floor=%0d pending=%h moving=%b enb=%b want 0 00 0 0", floor, pending, moving, tmr_enb); end
        total++; if (dir_up !== 1'b1 || door_open !== 1'b0 || tmr_modo !== 1'b0) begin bad++; $display("FAIL rstmid_flags: dir=%b door=%b modo=%b want 1 0 0", dir_up, door_open, tmr_modo); end
        tick();
        rst_n = 1'b1;
        req   = 8'h04;
        tick();
        req   = '0;
        total++; if (pending !== 8'h04) begin bad++; $display("FAIL rstmid_first_edge: pending=%h want 04", pending); end
    endtask

    task automatic test_top_floor();
        int n;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        req = 8'h80;
        tick();
        req = '0;
        tick();
        wait_door(1'b1, n);
        total++; if (n !== 35 || floor !== 3'd7) begin bad++; $display("FAIL top_reach: cycles=%0d floor=%0d want 35 7", n, floor); end
        wait_door(1'b0, n);
        req = 8'h01;
        tick();
        req = '0;
        tick();
        total++; if (moving !== 1'b1 || dir_up !== 1'b0 || floor !== 3'd7) begin bad++; $display("FAIL top_turn: moving=%b dir=%b floor=%0d want 1 0 7", moving, dir_up, floor); end
        wait_door(1'b1, n);
        total++; if (floor !== 3'd0) begin bad++; $display("FAIL top_back: floor=%0d want 0", floor); end
        wait_door(1'b0, n);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        test_reset();
        test_door_here();
        test_travel_up();
        test_both_directions();
        test_mid_hop_stop();
        test_reset_mid_hop();
        test_top_floor();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ascensor_ctrl.md
ASCENSOR_CTRL -- requirements
Module: ascensor_ctrl

Interface
REQ-001 Parameter N_FLOORS, default 8, number of served floors (floor index 0..N_FLOORS-1).
REQ-002 Parameter DOOR_TICKS, default 10, door-open count limit (1..16).
REQ-003 Parameter TRAVEL_TICKS, default 4, per-floor travel count limit (1..16).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req  input  N_FLOORS  floor call buttons, one bit per floor, sampled every edge.
REQ-007 tmr_enb  output  1  enable to the downstream 4-bit Counter.
REQ-008 tmr_modo  output  1  Counter mode: 1 = load tmr_data, 0 = count up.
REQ-009 tmr_data  output  4  Counter load value.
REQ-010 tmr_q  input  4  Counter value Q; load/increment visible one edge after request, wraps 15->0.
REQ-011 floor  output  3  current floor index.
REQ-012 dir_up  output  1  direction register: 1 = up, 0 = down.
REQ-013 moving  output  1  high in MOVE_UP or MOVE_DN.
REQ-014 door_open  output  1  high in DOOR_OPEN.
REQ-015 pending  output  N_FLOORS  latched outstanding requests.

Function
REQ-016 States SHALL be IDLE, DOOR_OPEN, MOVE_UP, MOVE_DN; one-bit register arm SHALL be set on every state entry (including MOVE re-entry) and cleared after one cycle.
REQ-017 While arm=1: tmr_enb=1, tmr_modo=1, tmr_data=0; in DOOR_OPEN/MOVE_* with arm=0: tmr_enb=1, tmr_modo=0; in IDLE: tmr_enb=0, tmr_modo=0, tmr_data=0.
REQ-018 Timer done SHALL be arm=0 and tmr_q==LIMIT, LIMIT = DOOR_TICKS-1 (DOOR_OPEN) or TRAVEL_TICKS-1 (MOVE_*); tmr_q SHALL be ignored while arm=1.
REQ-019 Each DOOR_OPEN visit SHALL last exactly DOOR_TICKS+1 cycles; each floor hop exactly TRAVEL_TICKS+1 cycles.
REQ-020 pending[i] next = (pending[i] | req[i]) & ~clr[i]; clr[floor]=1 every DOOR_OPEN cycle, so clear wins; req for current floor during DOOR_OPEN is dropped.
REQ-021 IDLE: pending[floor] -> DOOR_OPEN; else requests in dir_up direction -> keep direction, enter MOVE; else requests opposite -> toggle dir_up, enter MOVE; else stay IDLE.
REQ-022 MOVE_UP done: floor+1; MOVE_DN done: floor-1; then pending[new floor] -> DOOR_OPEN, else further requests same direction -> re-enter MOVE (arm=1), else IDLE.
REQ-023 Requests raised mid-hop SHALL be honoured at the next arrival check (stop at intermediate floor).
REQ-024 DOOR_OPEN done -> IDLE.
REQ-025 floor SHALL never leave 0..N_FLOORS-1; no MOVE_UP at top floor, no MOVE_DN at floor 0.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, arm=0, floor=0, dir_up=1, pending=0, moving=0, door_open=0, tmr_enb=0, tmr_modo=0, tmr_data=0, including mid-move or mid-door.
REQ-027 First edge after rst_n release SHALL sample req normally.

Structure
REQ-028 Package ascensor_pkg SHALL hold state encoding and default N_FLOORS, DOOR_TICKS, TRAVEL_TICKS.
REQ-029 Sub-module req_latch SHALL own the pending register bank (set/clear) and produce any_above/any_below relative to floor.
REQ-030 FSM, arm flag and timer-port decode SHALL reside in ascensor_ctrl; Counter remains external.

Verification (defaults, real Counter attached)
REQ-031 Reset, req=0 for 20 cycles -> IDLE, floor=0, dir_up=1, all other outputs 0.
REQ-032 floor 0, req[0] one-cycle pulse -> pending[0]=1 next edge, door_open high exactly 11 cycles, pending[0]=0, back to IDLE.
REQ-033 floor 0, req[3] pulse -> moving=1, dir_up=1, floor 1,2,3 every 5 cycles, then door_open at floor 3 for 11 cycles.
REQ-034 IDLE at floor 3, dir_up=1, req[1] and req[6] same cycle -> serve 6 first, then dir_up=0, serve 1.
REQ-035 moving up 3->6, req[5] pulse during hop 3->4 -> stops with door_open at 5, then continues to 6.
REQ-036 rst_n low during hop 2->3 with pending[5]=1 -> same cycle floor=0, pending=0, moving=0, tmr_enb=0.
